// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver FSM encoding and default frame width.
// The transmitter side uses the same SPI_WIDTH.
package spi_pkg;

    localparam int SPI_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        END  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_rx_slave_if.sv
// SPI receive link: serial pins from the transmitter plus the parallel word
// handed to the register/FIFO side.
interface spi_rx_slave_if #(
    parameter int WIDTH = spi_pkg::SPI_WIDTH
);
    logic             cs;
    logic             sclk;
    logic             mosi;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             err;
    logic             busy;

    modport master (
        output cs, sclk, mosi,
        input  dout, dout_valid, err, busy
    );

    modport slave (
        input  cs, sclk, mosi,
        output dout, dout_valid, err, busy
    );
endinterface

// File: rtl/spi_sync_edge.sv
// One-bit synchroniser with a previous-value register; emits the synchronised
// level and single-cycle rise/fall pulses in the clk domain.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign q    = sync[SYNC_STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_rx_slave.sv
// SPI receive endpoint: oversamples cs/sclk/mosi in the clk domain, samples
// mosi on sclk falling edges and strobes out each complete WIDTH-bit word.
module spi_rx_slave
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter bit LSB_FIRST   = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    spi_rx_slave_if.slave bus
);
    localparam int             CW   = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]  FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  OVF  = CW'(WIDTH + 1);

    logic cs_s, cs_rise, cs_fall;
    logic sclk_s, sclk_fall, sclk_rise_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.cs),
        .q    (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.sclk),
        .q    (sclk_s),
        .rise (sclk_rise_unused),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.mosi),
        .q    (mosi_s),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    spi_state_e       state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] sh, sh_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sh     <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            sh     <= sh_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sh_d    = sh;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                // sclk edges coinciding with the cs_fall belong to no frame
                if (cs_fall) begin
                    cnt_d   = '0;
                    sh_d    = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_d = END;
                end else if (sclk_fall) begin
                    if (cnt < FULL) begin
                        sh_d  = LSB_FIRST ? {mosi_s, sh[WIDTH-1:1]}
                                          : {sh[WIDTH-2:0], mosi_s};
                        cnt_d = cnt + 1'b1;
                    end else begin
                        cnt_d = OVF;
                    end
                end
            end
            END: begin
                if (cnt == FULL) begin
                    dout_d = sh;
                    vld_d  = 1'b1;
                end else begin
                    err_d  = 1'b1;
                end
                // A cs pulse of one synchronised cycle lands its fall here
                if (cs_fall) begin
                    cnt_d   = '0;
                    sh_d    = '0;
                    state_d = RECV;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = vld_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;

    // Synchronised sclk level only matters through its fall pulse.
    logic sclk_level_unused;
    assign sclk_level_unused = sclk_s;
endmodule
